// File: rtl/codec_cfg_ctrl.sv
// Power-up sequencer for the I2S audio codec: writes a fixed register table over a
// write-only open-drain I2C master, then raises i2s_enable. Reports done or error.
module codec_cfg_ctrl #(
  parameter int         CLK_DIV    = 125,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         SETTLE_CYC = 1000000
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       start,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       i2s_enable,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] fail_idx
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [3:0] SETTLE_IDX = 4'd10;
  localparam logic [3:0] LAST_IDX   = 4'd11;

  typedef enum logic [3:0] {
    ST_BOOT, ST_START, ST_BIT, ST_ACK, ST_STOP, ST_GAP, ST_SETTLE, ST_DONE, ST_ERROR
  } state_t;

  state_t          state, state_d;
  logic [1:0]      q, q_d;
  logic [2:0]      bit_cnt, bit_d;
  logic [1:0]      byte_cnt, byte_d;
  logic [3:0]      idx, idx_d;
  logic [RW-1:0]   retry, retry_d;
  logic            nack, nack_d;
  logic [SW-1:0]   settle_cnt, settle_d;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            scl_d, sda_d, busy_d, done_d, error_d, en_d;
  logic [3:0]      fail_d;
  logic [15:0]     cur_entry;
  logic [7:0]      cur_byte;
  logic            cur_bit;

  // Each entry is {reg[6:0], data[8:0]}, so its upper byte is exactly I2C byte1.
  function automatic logic [15:0] table_entry(input logic [3:0] i);
    case (i)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h010};
      4'd2:    table_entry = {7'd0,  9'h017};
      4'd3:    table_entry = {7'd1,  9'h017};
      4'd4:    table_entry = {7'd2,  9'h079};
      4'd5:    table_entry = {7'd3,  9'h079};
      4'd6:    table_entry = {7'd4,  9'h012};
      4'd7:    table_entry = {7'd5,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h00A};
      4'd9:    table_entry = {7'd8,  9'h000};
      4'd10:   table_entry = {7'd9,  9'h001};
      default: table_entry = {7'd6,  9'h000};
    endcase
  endfunction

  assign cur_entry = table_entry(idx);
  always_comb begin
    case (byte_cnt)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = cur_entry[15:8];
      default: cur_byte = cur_entry[7:0];
    endcase
  end
  assign cur_bit = cur_byte[bit_cnt];

  assign tick = busy && (tick_cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)           tick_cnt <= '0;
    else if (!busy || tick) tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BOOT;
      q          <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      idx        <= '0;
      retry      <= '0;
      nack       <= 1'b0;
      settle_cnt <= '0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      i2s_enable <= 1'b0;
      fail_idx   <= '0;
    end else begin
      state      <= state_d;
      q          <= q_d;
      bit_cnt    <= bit_d;
      byte_cnt   <= byte_d;
      idx        <= idx_d;
      retry      <= retry_d;
      nack       <= nack_d;
      settle_cnt <= settle_d;
      scl_oe     <= scl_d;
      sda_oe     <= sda_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      i2s_enable <= en_d;
      fail_idx   <= fail_d;
    end
  end

  always_comb begin
    state_d  = state;
    q_d      = q;
    bit_d    = bit_cnt;
    byte_d   = byte_cnt;
    idx_d    = idx;
    retry_d  = retry;
    nack_d   = nack;
    settle_d = settle_cnt;
    scl_d    = scl_oe;
    sda_d    = sda_oe;
    busy_d   = busy;
    done_d   = done;
    error_d  = error;
    en_d     = i2s_enable;
    fail_d   = fail_idx;
    case (state)
      ST_BOOT: begin
        busy_d  = 1'b1;
        idx_d   = '0;
        retry_d = '0;
        q_d     = '0;
        state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (q == 2'd0) begin
          sda_d = 1'b1;
          q_d   = 2'd1;
        end else begin
          scl_d   = 1'b1;
          q_d     = 2'd0;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
          nack_d  = 1'b0;
          state_d = ST_BIT;
        end
      end
      ST_BIT: if (tick) begin
        q_d = q + 2'd1;
        if (q == 2'd0) sda_d = ~cur_bit;
        if (q == 2'd1) scl_d = 1'b0;
        if (q == 2'd3) begin
          scl_d = 1'b1;
          if (bit_cnt == 3'd0) state_d = ST_ACK;
          else                 bit_d   = bit_cnt - 3'd1;
        end
      end
      ST_ACK: if (tick) begin
        q_d = q + 2'd1;
        if (q == 2'd0) sda_d  = 1'b0;
        if (q == 2'd1) scl_d  = 1'b0;
        if (q == 2'd2) nack_d = sda_in;
        if (q == 2'd3) begin
          scl_d = 1'b1;
          if (nack || byte_cnt == 2'd2) begin
            state_d = ST_STOP;
          end else begin
            byte_d  = byte_cnt + 2'd1;
            bit_d   = 3'd7;
            state_d = ST_BIT;
          end
        end
      end
      ST_STOP: if (tick) begin
        if (q == 2'd0) begin
          sda_d = 1'b1;
          q_d   = 2'd1;
        end else if (q == 2'd1) begin
          scl_d = 1'b0;
          q_d   = 2'd2;
        end else begin
          // Final STOP tick also decides what follows the frame.
          sda_d = 1'b0;
          q_d   = 2'd0;
          if (nack) begin
            if (retry == RW'(MAX_RETRY - 1)) begin
              error_d = 1'b1;
              fail_d  = idx;
              busy_d  = 1'b0;
              en_d    = 1'b0;
              state_d = ST_ERROR;
            end else begin
              retry_d = retry + 1'b1;
              state_d = ST_GAP;
            end
          end else begin
            retry_d = '0;
            if (idx == LAST_IDX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              en_d    = 1'b1;
              state_d = ST_DONE;
            end else if (idx == SETTLE_IDX) begin
              idx_d    = idx + 4'd1;
              settle_d = '0;
              state_d  = ST_SETTLE;
            end else begin
              idx_d   = idx + 4'd1;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: if (tick) begin
        q_d = q + 2'd1;
        if (q == 2'd3) state_d = ST_START;
      end
      ST_SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
          q_d     = 2'd0;
          state_d = ST_START;
        end else begin
          settle_d = settle_cnt + 1'b1;
        end
      end
      ST_DONE, ST_ERROR: if (start) begin
        done_d  = 1'b0;
        error_d = 1'b0;
        fail_d  = '0;
        en_d    = 1'b0;
        busy_d  = 1'b1;
        idx_d   = '0;
        retry_d = '0;
        q_d     = 2'd0;
        state_d = ST_START;
      end
      default: state_d = ST_BOOT;
    endcase
  end
endmodule

// File: tb/tb_codec_cfg_ctrl.sv
// Bench for codec_cfg_ctrl: an I2C bus monitor plus scripted slave, scored against
// a table-level model of the expected byte stream and final outcome.
module tb_codec_cfg_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int SETTLE    = 20;
  localparam int MAX_RETRY = 3;
  localparam int SCL_PER   = 4 * CLK_DIV;
  localparam int BUDGET    = 20000;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       scl_oe, sda_oe, sda_in;
  logic       i2s_enable, busy, done, error;
  logic [3:0] fail_idx;
  logic       ack_drive = 1'b0;

  codec_cfg_ctrl #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A), .MAX_RETRY(MAX_RETRY),
                   .SETTLE_CYC(SETTLE)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .start(start), .scl_oe(scl_oe),
    .sda_oe(sda_oe), .sda_in(sda_in), .i2s_enable(i2s_enable), .busy(busy),
    .done(done), .error(error), .fail_idx(fail_idx)
  );

  assign sda_in = ~(sda_oe | ack_drive);

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register table at the datasheet level: register number and 9-bit value.
  int reg_tab[12] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9, 6};
  int dat_tab[12] = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000,
                      'h00A, 'h000, 'h001, 'h000};

  int n_cnt[12];
  int n_byte[12];
  logic [7:0] exp_q[$];
  int plan_q[$];
  bit m_done, m_err;
  int m_fail, m_frames;

  task automatic clear_plan();
    for (int i = 0; i < 12; i++) begin
      n_cnt[i]  = 0;
      n_byte[i] = 0;
    end
  endtask

  task automatic build_model();
    logic [7:0] b[3];
    int att;
    exp_q.delete();
    plan_q.delete();
    m_done = 0; m_err = 0; m_fail = 0; m_frames = 0;
    for (int i = 0; i < 12; i++) begin
      b[0] = 8'h34;
      b[1] = 8'((reg_tab[i] * 2) + (dat_tab[i] / 256));
      b[2] = 8'(dat_tab[i] % 256);
      att = 0;
      while (att < n_cnt[i] && att < MAX_RETRY) begin
        for (int k = 0; k <= n_byte[i]; k++) exp_q.push_back(b[k]);
        plan_q.push_back(n_byte[i]);
        m_frames++;
        att++;
      end
      if (att == MAX_RETRY) begin
        m_err  = 1;
        m_fail = i;
        return;
      end
      for (int k = 0; k < 3; k++) exp_q.push_back(b[k]);
      plan_q.push_back(3);
      m_frames++;
    end
    m_done = 1;
  endtask

  // Bus monitor and scripted slave, sampled on the falling sysclk edge.
  int bitcnt = 0, byte_in_frame = 0, cur_nack = 3;
  int frames_started = 0, stops_seen = 0, last_rise = 0, cyc = 0;
  logic [7:0] shreg = 8'h00;
  bit scl_p = 1, sda_p = 1, done_p = 0;
  bit scl_c, sda_c;

  always @(negedge sysclk) begin
    cyc++;
    if (!reset_n) begin
      bitcnt = 0; byte_in_frame = 0; ack_drive = 1'b0;
      scl_p = 1; sda_p = 1; done_p = 0;
    end else begin
      scl_c = ~scl_oe;
      sda_c = sda_in;
      if (scl_p && scl_c && (sda_p != sda_c)) begin
        if (!sda_c) begin
          chk("start_outside_byte", bitcnt, 0);
          frames_started++;
          byte_in_frame = 0;
          bitcnt = 0;
          cur_nack = (plan_q.size() > 0) ? plan_q.pop_front() : 3;
        end else begin
          chk("stop_outside_byte", 32'(bitcnt <= 1), 1);
          stops_seen++;
          bitcnt = 0;
        end
      end else if (!scl_p && scl_c) begin
        if (bitcnt >= 1) chk("scl_period", cyc - last_rise, SCL_PER);
        last_rise = cyc;
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], sda_c};
          bitcnt++;
        end else if (bitcnt == 8) begin
          chk("ack_slot_released", sda_oe, 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_unexpected: got %0h expected none", shreg);
          end else begin
            chk("byte", shreg, exp_q.pop_front());
          end
          byte_in_frame++;
          bitcnt = 9;
        end
      end else if (scl_p && !scl_c) begin
        if (bitcnt == 8) ack_drive = (byte_in_frame != cur_nack);
        else if (bitcnt == 9) begin
          ack_drive = 1'b0;
          bitcnt = 0;
        end
      end
      if (done && !done_p) begin
        chk("done_en_same_cycle", i2s_enable, 1);
        chk("done_busy_same_cycle", busy, 0);
      end
      done_p = done;
      scl_p  = scl_c;
      sda_p  = sda_c;
    end
  end

  task automatic run_from_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge sysclk);
    build_model();
    frames_started = 0;
    stops_seen = 0;
    reset_n = 1'b1;
  endtask

  task automatic wait_end();
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sysclk);
      if (done || error) break;
    end
    chk("sequence_finished", 32'(done | error), 1);
    repeat (2) @(negedge sysclk);
  endtask

  task automatic check_outcome(input bit e_done, input bit e_err, input int e_fail,
                               input int e_frames);
    chk("done", done, e_done);
    chk("error", error, e_err);
    chk("fail_idx", fail_idx, e_fail);
    chk("i2s_enable", i2s_enable, e_done);
    chk("busy_end", busy, 0);
    chk("scl_released", scl_oe, 0);
    chk("sda_released", sda_oe, 0);
    chk("bytes_left", exp_q.size(), 0);
    chk("frames", frames_started, e_frames);
  endtask

  task automatic pulse_start();
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  typedef struct {
    int nidx;
    int ncnt;
    int nbyte;
    bit edone;
    bit eerr;
    int efail;
    int eframes;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{nidx: -1, ncnt: 0, nbyte: 0, edone: 1, eerr: 0, efail: 0, eframes: 12};
    vecs[1] = '{nidx: 3,  ncnt: 2, nbyte: 0, edone: 1, eerr: 0, efail: 0, eframes: 14};
    vecs[2] = '{nidx: 11, ncnt: 1, nbyte: 2, edone: 1, eerr: 0, efail: 0, eframes: 13};
    vecs[3] = '{nidx: 5,  ncnt: 3, nbyte: 0, edone: 0, eerr: 1, efail: 5, eframes: 8};

    #1 reset_n = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_i2s_enable", i2s_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_fail_idx", fail_idx, 0);

    for (int v = 0; v < 4; v++) begin
      clear_plan();
      if (vecs[v].nidx >= 0) begin
        n_cnt[vecs[v].nidx]  = vecs[v].ncnt;
        n_byte[vecs[v].nidx] = vecs[v].nbyte;
      end
      run_from_reset();
      @(negedge sysclk);
      chk("boot_busy", busy, 1);
      wait_end();
      check_outcome(vecs[v].edone, vecs[v].eerr, vecs[v].efail, vecs[v].eframes);
    end

    // ERROR -> start reruns the whole table from entry 0.
    clear_plan();
    build_model();
    frames_started = 0;
    stops_seen = 0;
    pulse_start();
    chk("restart_error_clr", error, 0);
    chk("restart_fail_clr", fail_idx, 0);
    chk("restart_busy", busy, 1);
    wait_end();
    check_outcome(1, 0, 0, 12);

    // Reset in the middle of entry 2.
    clear_plan();
    run_from_reset();
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sysclk);
      if (frames_started == 3 && bitcnt == 4) break;
    end
    chk("reached_entry2", frames_started, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_i2s_enable", i2s_enable, 0);
    run_from_reset();
    wait_end();
    check_outcome(1, 0, 0, 12);

    // start while busy: during entry 4 and during the settle wait.
    clear_plan();
    run_from_reset();
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sysclk);
      if (frames_started == 5) break;
    end
    pulse_start();
    chk("busy_start_ignored", busy, 1);
    chk("busy_start_no_done", done, 0);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sysclk);
      if (stops_seen == 11) break;
    end
    repeat (3) @(negedge sysclk);
    pulse_start();
    chk("settle_busy", busy, 1);
    chk("settle_scl_released", scl_oe, 0);
    chk("settle_sda_released", sda_oe, 0);
    chk("settle_frames", frames_started, 11);
    wait_end();
    check_outcome(1, 0, 0, 12);

    // Randomized slave NACK patterns against the model.
    for (int r = 0; r < 3; r++) begin
      clear_plan();
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          n_cnt[i]  = $urandom_range(1, 3);
          n_byte[i] = $urandom_range(0, 2);
        end
      end
      run_from_reset();
      wait_end();
      check_outcome(m_done, m_err, m_fail, m_frames);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
